vga_output_unit: RTL and testbench

VGA_OUTPUT_UNIT -- requirements
Module: vga_output_unit

---
 rtl/vga_output_unit.sv | 129 ++++++++++++
 tb/tb_vga_output_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_output_unit.sv
// VGA 640x480@60 timing generator with a registered, colour-aligned rgb/sync output stage.
// Sync and blanking are delayed PIPE_DELAY cycles so they meet the sprite colour for the same pixel.
module vga_output_unit #(
  parameter int unsigned PIPE_DELAY = 2,
  parameter logic [5:0]  FG_RGB     = 6'b111111,
  parameter logic [5:0]  BG_RGB     = 6'b000000,
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       colour,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic       display_on,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] HLast      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] VLast      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] fc_q, fc_d;
  logic       h_wrap, v_wrap;

  logic       hs_raw, vs_raw, de_raw;

  logic [PIPE_DELAY-1:0] hs_pipe, vs_pipe, de_pipe;
  logic [PIPE_DELAY:0]   hs_shift, vs_shift, de_shift;

  logic [5:0] rgb_q, rgb_d;
  logic       hsync_q, vsync_q;

  // Wrap on >= so the counters can never leave their range.
  always_comb begin
    h_wrap = (h_q >= HLast);
    v_wrap = (v_q >= VLast);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    fc_d   = fc_q;
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      if (v_wrap) begin
        fc_d = fc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      h_q  <= 10'd0;
      v_q  <= 10'd0;
      fc_q <= 8'd0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fc_q <= fc_d;
    end
  end

  always_comb begin
    hs_raw = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
    vs_raw = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
    de_raw = (h_q < HVis) && (v_q < VVis);
  end

  assign hs_shift = {hs_pipe, hs_raw};
  assign vs_shift = {vs_pipe, vs_raw};
  assign de_shift = {de_pipe, de_raw};

  // Reset stages to idle sync and blanked display so nothing false leaves after release.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else begin
      hs_pipe <= hs_shift[PIPE_DELAY-1:0];
      vs_pipe <= vs_shift[PIPE_DELAY-1:0];
      de_pipe <= de_shift[PIPE_DELAY-1:0];
    end
  end

  always_comb begin
    rgb_d = 6'b000000;
    if (de_pipe[PIPE_DELAY-1]) begin
      rgb_d = colour ? FG_RGB : BG_RGB;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rgb_q   <= 6'b000000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hs_pipe[PIPE_DELAY-1];
      vsync_q <= vs_pipe[PIPE_DELAY-1];
    end
  end

  assign counter_H   = h_q;
  assign counter_V   = v_q;
  assign frame_count = fc_q;
  assign display_on  = de_raw;
  assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_output_unit.sv
// Scoreboard bench for vga_output_unit: a full-size instance and a shrunken-geometry instance
// run side by side against a position/colour reference model.
module tb_vga_output_unit;

  logic clk;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D  = (g == 0) ? 2 : 3;
    localparam int HV = (g == 0) ? 640 : 8;
    localparam int HF = (g == 0) ? 16 : 2;
    localparam int HS = (g == 0) ? 96 : 3;
    localparam int HB = (g == 0) ? 48 : 2;
    localparam int VV = (g == 0) ? 480 : 6;
    localparam int VF = (g == 0) ? 10 : 1;
    localparam int VS = 2;
    localparam int VB = (g == 0) ? 33 : 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam logic [5:0] FG = (g == 0) ? 6'b111111 : 6'b101010;
    localparam logic [5:0] BG = (g == 0) ? 6'b000000 : 6'b010101;
    // First run ends mid-frame at (h=300,v=3) or, for the small instance, after 256 frames.
    localparam int N1     = (g == 0) ? (3 * HT + 300) : (256 * HT * VT + 4 * HT + 5);
    localparam int N2     = (g == 0) ? (2 * HT + 50) : (3 * HT * VT);
    localparam int FS_EXP = N1 / (HT * VT) + 1;

    logic       rst_n;
    logic       colour;
    logic [9:0] ch, cv;
    logic       hsync, vsync, display_on, frame_start;
    logic [5:0] rgb;
    logic [7:0] fc;
    logic       running = 1'b0;
    logic [7:0] exp_q[$];
    int         pos_hist[$];
    int         mh, mv, frames, fs_seen;
    logic [7:0] e;

    vga_output_unit #(
      .PIPE_DELAY(D), .FG_RGB(FG), .BG_RGB(BG),
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut (
      .clk_in      (clk),
      .reset       (rst_n),
      .colour      (colour),
      .counter_H   (ch),
      .counter_V   (cv),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .display_on  (display_on),
      .frame_start (frame_start),
      .frame_count (fc)
    );

    // {rgb, hsync, vsync} that the pixel at (h,v) with colour c should produce.
    function automatic logic [7:0] expect_out(int h, int v, logic c);
      logic       vis;
      logic       hs_n, vs_n;
      logic [5:0] px;
      vis  = (h < HV) && (v < VV);
      hs_n = !((h >= HV + HF) && (h < HV + HF + HS));
      vs_n = !((v >= VV + VF) && (v < VV + VF + VS));
      px   = vis ? (c ? FG : BG) : 6'b000000;
      return {px, hs_n, vs_n};
    endfunction

    task automatic chk(string name, int act, int expv);
      checks++;
      if (act != expv) begin
        failures++;
        $display("FAIL dut%0d %s: got %0d expected %0d at t=%0t", g, name, act, expv, $time);
      end
    endtask

    task automatic reset_checks(string tag);
      chk({tag, " counter_H"}, int'(ch), 0);
      chk({tag, " counter_V"}, int'(cv), 0);
      chk({tag, " rgb"}, int'(rgb), 0);
      chk({tag, " hsync"}, int'(hsync), 1);
      chk({tag, " vsync"}, int'(vsync), 1);
      chk({tag, " display_on"}, int'(display_on), 1);
      chk({tag, " frame_start"}, int'(frame_start), 1);
      chk({tag, " frame_count"}, int'(fc), 0);
    endtask

    // Called on a falling edge with reset asserted; releases it and runs n pixel cycles.
    task automatic run(int n, bit rand_colour);
      int p;
      exp_q.delete();
      pos_hist.delete();
      exp_q.push_back({6'b000000, 2'b11});
      mh = 0; mv = 0; frames = 0; fs_seen = 0;
      rst_n   = 1'b1;
      running = 1'b1;
      for (int t = 0; t < n; t++) begin
        colour = rand_colour ? 1'($urandom) : 1'b1;
        chk("counter_H", int'(ch), mh);
        chk("counter_V", int'(cv), mv);
        chk("display_on", int'(display_on), int'((mh < HV) && (mv < VV)));
        chk("frame_start", int'(frame_start), int'((mh == 0) && (mv == 0)));
        chk("frame_count", int'(fc), frames % 256);
        if (frame_start) fs_seen++;
        pos_hist.push_back(mh * 1024 + mv);
        if (pos_hist.size() > D) begin
          p = pos_hist.pop_front();
          exp_q.push_back(expect_out(p / 1024, p % 1024, colour));
        end else begin
          exp_q.push_back({6'b000000, 2'b11});
        end
        @(negedge clk);
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) begin
            mv = 0;
            frames++;
          end
        end
      end
      running = 1'b0;
    endtask

    always @(negedge clk) begin
      #1;
      if (running) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL dut%0d scoreboard: got empty queue expected an entry at t=%0t", g, $time);
        end else begin
          e = exp_q.pop_front();
          if ({rgb, hsync, vsync} !== e) begin
            failures++;
            $display("FAIL dut%0d rgb/hsync/vsync: got %b/%b/%b expected %b/%b/%b at t=%0t",
                     g, rgb, hsync, vsync, e[7:2], e[1], e[0], $time);
          end
        end
      end
    end

    initial begin
      rst_n  = 1'b0;
      colour = 1'b0;
      repeat (3) @(negedge clk);
      reset_checks("por");
      run(N1, 1'b1);
      chk("frame_start pulses", fs_seen, FS_EXP);
      chk("frame_count after run", int'(fc), (N1 / (HT * VT)) % 256);
      // Mid-frame reset must act without waiting for a clock edge.
      #2 rst_n = 1'b0;
      #1 reset_checks("async");
      repeat (4) @(negedge clk);
      reset_checks("held");
      run(N2, g != 0);
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == 2);
      #1_000_000;
    join_any
    if (done_cnt != 2) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d finished instances expected 2", done_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
